// File: rtl/third_step_exec.sv
// MIPS execute stage: branch-target adder, ALU operand select, ALU control
// decode, ALU, destination-register select, and the EX/MEM output register.
module third_step_exec (
  input  logic        clk,
  input  logic        reset,
  input  logic        aluSrc,
  input  logic [1:0]  ALUOp,
  input  logic        regDst,
  input  logic [31:0] pcPlusFour,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] signExtend,
  input  logic [4:0]  regDst1,
  input  logic [4:0]  regDst2,
  output logic [31:0] addResult,
  output logic        zero,
  output logic [31:0] aluResult,
  output logic [31:0] reg2Out,
  output logic [4:0]  muxRegDstOut
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CTRL_W  = 3;

  // ALU operation encodings (internal only)
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'd4;
  localparam logic [CTRL_W-1:0] ALU_NOR = 3'd5;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'd6;

  // R-type funct codes
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;

  logic [FUNCT_W-1:0] funct_c;
  logic [CTRL_W-1:0]  alu_ctrl_c;
  logic [DATA_W-1:0]  alu_b_c;
  logic [DATA_W-1:0]  alu_res_c;
  logic [DATA_W-1:0]  branch_tgt_c;
  logic [REG_W-1:0]   dst_c;

  assign funct_c      = signExtend[FUNCT_W-1:0];
  assign alu_b_c      = aluSrc ? signExtend : reg2;
  assign branch_tgt_c = pcPlusFour + (signExtend << 2);
  assign dst_c        = regDst ? regDst2 : regDst1;

  // ALU control decode; unknown funct codes fall back to ADD
  always_comb begin
    alu_ctrl_c = ALU_ADD;
    case (ALUOp)
      2'b01: alu_ctrl_c = ALU_SUB;
      2'b10: begin
        case (funct_c)
          FN_ADD, FN_ADDU: alu_ctrl_c = ALU_ADD;
          FN_SUB, FN_SUBU: alu_ctrl_c = ALU_SUB;
          FN_AND:          alu_ctrl_c = ALU_AND;
          FN_OR:           alu_ctrl_c = ALU_OR;
          FN_XOR:          alu_ctrl_c = ALU_XOR;
          FN_NOR:          alu_ctrl_c = ALU_NOR;
          FN_SLT:          alu_ctrl_c = ALU_SLT;
          default:         alu_ctrl_c = ALU_ADD;
        endcase
      end
      default: alu_ctrl_c = ALU_ADD;
    endcase
  end

  // ALU datapath; add/sub wrap with no overflow indication
  always_comb begin
    alu_res_c = '0;
    case (alu_ctrl_c)
      ALU_ADD: alu_res_c = reg1 + alu_b_c;
      ALU_SUB: alu_res_c = reg1 - alu_b_c;
      ALU_AND: alu_res_c = reg1 & alu_b_c;
      ALU_OR:  alu_res_c = reg1 | alu_b_c;
      ALU_XOR: alu_res_c = reg1 ^ alu_b_c;
      ALU_NOR: alu_res_c = ~(reg1 | alu_b_c);
      ALU_SLT: alu_res_c = DATA_W'($signed(reg1) < $signed(alu_b_c));
      default: alu_res_c = reg1 + alu_b_c;
    endcase
  end

  // EX/MEM register; reset takes priority over new data
  always_ff @(posedge clk) begin
    if (reset) begin
      addResult    <= '0;
      zero         <= 1'b0;
      aluResult    <= '0;
      reg2Out      <= '0;
      muxRegDstOut <= '0;
    end else begin
      addResult    <= branch_tgt_c;
      zero         <= (alu_res_c == '0);
      aluResult    <= alu_res_c;
      reg2Out      <= reg2;
      muxRegDstOut <= dst_c;
    end
  end

endmodule

// File: tb/tb_third_step_exec.sv
// Self-checking bench for third_step_exec: directed spec vectors, corner
// cases, mid-stream reset and randomized back-to-back traffic, all checked
// through an expected-result queue.
module tb_third_step_exec;

  typedef struct packed {
    logic        rst;
    logic        src;
    logic [1:0]  op;
    logic        dsel;
    logic [31:0] pc4;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] se;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] r2;
    logic [4:0]  dst;
  } out_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluSrc;
  logic [1:0]  ALUOp;
  logic        regDst;
  logic [31:0] pcPlusFour, reg1, reg2, signExtend;
  logic [4:0]  regDst1, regDst2;
  logic [31:0] addResult, aluResult, reg2Out;
  logic        zero;
  logic [4:0]  muxRegDstOut;

  int n_checks = 0;
  int n_fail   = 0;
  out_t exp_q[$];

  third_step_exec dut (
    .clk(clk), .reset(reset), .aluSrc(aluSrc), .ALUOp(ALUOp), .regDst(regDst),
    .pcPlusFour(pcPlusFour), .reg1(reg1), .reg2(reg2), .signExtend(signExtend),
    .regDst1(regDst1), .regDst2(regDst2), .addResult(addResult), .zero(zero),
    .aluResult(aluResult), .reg2Out(reg2Out), .muxRegDstOut(muxRegDstOut)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic in_t mk_in(logic rst, logic src, logic [1:0] op, logic dsel,
                                logic [31:0] pc4, logic [31:0] r1, logic [31:0] r2,
                                logic [31:0] se, logic [4:0] rt, logic [4:0] rd);
    in_t v;
    v.rst = rst; v.src = src; v.op = op; v.dsel = dsel; v.pc4 = pc4;
    v.r1 = r1; v.r2 = r2; v.se = se; v.rt = rt; v.rd = rd;
    return v;
  endfunction

  function automatic out_t mk_out(logic [31:0] add, logic z, logic [31:0] alu,
                                  logic [31:0] r2, logic [4:0] dst);
    out_t o;
    o.add = add; o.zero = z; o.alu = alu; o.r2 = r2; o.dst = dst;
    return o;
  endfunction

  // Behavioural reference for randomized traffic
  function automatic out_t model(in_t v);
    out_t o;
    logic [31:0] b;
    logic [31:0] res;
    o = '0;
    if (v.rst) return o;
    b = v.src ? v.se : v.r2;
    res = v.r1 + b;
    if (v.op == 2'b01) res = v.r1 - b;
    else if (v.op == 2'b10) begin
      case (v.se[5:0])
        6'h22, 6'h23: res = v.r1 - b;
        6'h24: res = v.r1 & b;
        6'h25: res = v.r1 | b;
        6'h26: res = v.r1 ^ b;
        6'h27: res = ~(v.r1 | b);
        6'h2A: res = {31'b0, ($signed(v.r1) < $signed(b))};
        default: res = v.r1 + b;
      endcase
    end
    o.add  = v.pc4 + {v.se[29:0], 2'b00};
    o.alu  = res;
    o.zero = (res == 32'd0);
    o.r2   = v.r2;
    o.dst  = v.dsel ? v.rd : v.rt;
    return o;
  endfunction

  task automatic apply(input in_t v);
    reset = v.rst; aluSrc = v.src; ALUOp = v.op; regDst = v.dsel;
    pcPlusFour = v.pc4; reg1 = v.r1; reg2 = v.r2; signExtend = v.se;
    regDst1 = v.rt; regDst2 = v.rd;
  endtask

  function automatic out_t sample();
    return mk_out(addResult, zero, aluResult, reg2Out, muxRegDstOut);
  endfunction

  task automatic test_reset();
    out_t got, e;
    apply(mk_in(1'b1, 1'b1, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678,
                32'hFFFF_FFFF, 32'h0000_0025, 5'd31, 5'd17));
    exp_q.push_back('0);
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset: got=%h expected=%h", got, e);
    end
  endtask

  task automatic test_directed();
    in_t  vin [13];
    out_t vexp[13];
    out_t got, e;
    vin[0]  = mk_in(0, 0, 2'b00, 0, 32, 7, 3, 25, 5, 8);       vexp[0]  = mk_out(132, 0, 10, 3, 5);
    vin[1]  = mk_in(0, 0, 2'b00, 1, 32, 7, 3, 25, 5, 8);       vexp[1]  = mk_out(132, 0, 10, 3, 8);
    vin[2]  = mk_in(0, 0, 2'b10, 0, 32, 7, 3, 32'h22, 5, 8);   vexp[2]  = mk_out(168, 0, 4, 3, 5);
    vin[3]  = mk_in(0, 1, 2'b10, 0, 32, 7, 3, 32'h24, 5, 8);   vexp[3]  = mk_out(176, 0, 4, 3, 5);
    vin[4]  = mk_in(0, 1, 2'b10, 0, 32, 7, 3, 32'h25, 5, 8);   vexp[4]  = mk_out(180, 0, 39, 3, 5);
    vin[5]  = mk_in(0, 1, 2'b10, 0, 32, 7, 3, 32'h2A, 5, 8);   vexp[5]  = mk_out(200, 0, 1, 3, 5);
    vin[6]  = mk_in(0, 0, 2'b10, 0, 32, 7, 7, 32'h22, 5, 8);   vexp[6]  = mk_out(168, 1, 0, 7, 5);
    vin[7]  = mk_in(0, 0, 2'b10, 0, 32, 32'h8000_0000, 1, 32'h2A, 5, 8);
    vexp[7] = mk_out(200, 0, 1, 1, 5);
    vin[8]  = mk_in(0, 0, 2'b00, 0, 32, 32'hFFFF_FFFF, 1, 25, 5, 8);
    vexp[8] = mk_out(132, 1, 0, 1, 5);
    // NOR, XOR, ALUOp=01 subtract with immediate, negative branch offset
    vin[9]  = mk_in(0, 0, 2'b10, 1, 32, 32'h0F0F_0000, 32'h0000_F0F0, 32'h27, 1, 2);
    vexp[9] = mk_out(32 + 32'h9C, 0, 32'hF0F0_0F0F, 32'h0000_F0F0, 2);
    vin[10] = mk_in(0, 0, 2'b10, 1, 32, 32'hAAAA_5555, 32'hFFFF_0000, 32'h26, 1, 2);
    vexp[10] = mk_out(32 + 32'h98, 0, 32'h5555_5555, 32'hFFFF_0000, 2);
    vin[11] = mk_in(0, 1, 2'b01, 0, 32'h100, 10, 99, 32'hFFFF_FFFF, 3, 4);
    vexp[11] = mk_out(32'hFC, 0, 11, 99, 3);
    // Unknown funct with ALUOp=10 and ALUOp=11 both add
    vin[12] = mk_in(0, 1, 2'b11, 0, 32'hFFFF_FFFC, 5, 6, 32'h3F, 9, 10);
    vexp[12] = mk_out(32'hF8, 0, 32'h44, 6, 9);
    for (int i = 0; i < 13; i++) begin
      apply(vin[i]);
      exp_q.push_back(vexp[i]);
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL directed[%0d]: got add=%h z=%b alu=%h r2=%h dst=%0d expected add=%h z=%b alu=%h r2=%h dst=%0d",
                 i, got.add, got.zero, got.alu, got.r2, got.dst, e.add, e.zero, e.alu, e.r2, e.dst);
      end
    end
  endtask

  task automatic test_unknown_funct();
    out_t got, e;
    apply(mk_in(0, 0, 2'b10, 0, 0, 20, 22, 32'h3C, 7, 8));
    exp_q.push_back(mk_out(32'hF0, 0, 42, 22, 7));
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL unknown_funct: got=%h expected=%h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    in_t  seq[4];
    out_t got, e;
    seq[0] = mk_in(0, 0, 2'b00, 1, 32, 7, 3, 25, 5, 8);
    seq[1] = mk_in(1, 0, 2'b00, 1, 64, 9, 9, 1, 5, 8);
    seq[2] = mk_in(0, 0, 2'b01, 1, 64, 9, 9, 1, 5, 8);
    seq[3] = mk_in(0, 1, 2'b10, 0, 4, 32'hFFFF_FFF0, 0, 32'h2A, 12, 13);
    for (int i = 0; i < 4; i++) begin
      apply(seq[i]);
      exp_q.push_back(model(seq[i]));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got=%h expected=%h", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn_tab[10];
    in_t  v;
    out_t got, e;
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
    for (int i = 0; i < 60; i++) begin
      v.rst  = ($urandom_range(0, 19) == 0);
      v.src  = 1'($urandom);
      v.op   = 2'($urandom);
      v.dsel = 1'($urandom);
      v.pc4  = $urandom;
      v.r1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      v.r2   = ($urandom_range(0, 5) == 0) ? v.r1 : $urandom;
      v.se   = $urandom;
      v.se[5:0] = fn_tab[$urandom_range(0, 9)];
      v.rt   = 5'($urandom);
      v.rd   = 5'($urandom);
      apply(v);
      exp_q.push_back(model(v));
      @(posedge clk); #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got=%h expected=%h", i, got, e);
      end
    end
  endtask

  initial begin
    apply('0);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_unknown_funct();
    test_reset_mid();
    test_back_to_back();
    test_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got=%0d entries expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
